// File: rtl/primo_pkg.sv
// Shared constants, operand type and elaboration-time primality helpers for primo_detector.
package primo_pkg;

    localparam int unsigned MAX_W = 8;

    typedef logic [MAX_W-1:0] operand_t;

    // Smallest divisor d >= 2 of a composite n; 0 for primes, 0 and 1.
    function automatic int smallest_factor(int n);
        if (n < 2) return 0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return d;
        end
        return 0;
    endfunction

    function automatic logic is_prime(int n);
        return (n >= 2) && (smallest_factor(n) == 0);
    endfunction

endpackage

// File: rtl/primo_lut.sv
// Combinational N -> {prime, factor} lookup built from constant tables at elaboration.
// Factor table and port exist only when PRIMO_FACTOR_EN is defined.
module primo_lut
    import primo_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] n,
    output logic         prime
`ifdef PRIMO_FACTOR_EN
    ,
    output logic [W-1:0] factor
`endif
);

    localparam int unsigned DEPTH = 1 << W;

    typedef logic [DEPTH-1:0] prime_tbl_t;

    function automatic prime_tbl_t build_prime_tbl();
        prime_tbl_t t;
        t = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            t[i] = is_prime(i);
        end
        return t;
    endfunction

    localparam prime_tbl_t PRIME_TBL = build_prime_tbl();

    assign prime = PRIME_TBL[n];

`ifdef PRIMO_FACTOR_EN
    typedef logic [DEPTH-1:0][W-1:0] factor_tbl_t;

    function automatic factor_tbl_t build_factor_tbl();
        factor_tbl_t t;
        t = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            t[i] = W'(smallest_factor(i));
        end
        return t;
    endfunction

    localparam factor_tbl_t FACTOR_TBL = build_factor_tbl();

    assign factor = FACTOR_TBL[n];
`endif

endmodule

// File: rtl/primo_detector.sv
// Registered primality detector: one-cycle latency, full throughput, F holds when idle.
// Optional FACTOR output (smallest divisor of composite N) enabled by PRIMO_FACTOR_EN.
module primo_detector
    import primo_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] N,
    output logic         out_vld,
    output logic         F
`ifdef PRIMO_FACTOR_EN
    ,
    output logic [W-1:0] FACTOR
`endif
);

    logic prime_c;
`ifdef PRIMO_FACTOR_EN
    logic [W-1:0] factor_c;
`endif

    primo_lut #(.W(W)) u_lut (
        .n     (N),
        .prime (prime_c)
`ifdef PRIMO_FACTOR_EN
        ,
        .factor(factor_c)
`endif
    );

    // Result registers only load on valid input so they hold across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            F       <= 1'b0;
`ifdef PRIMO_FACTOR_EN
            FACTOR  <= '0;
`endif
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                F      <= prime_c;
`ifdef PRIMO_FACTOR_EN
                FACTOR <= factor_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_primo_detector.sv
// Self-checking bench for primo_detector (W=4 main instance plus a W=8 instance).
module tb_primo_detector;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld;
    logic [W-1:0] n;
    logic [7:0]   n8;
    logic         out_vld, f;
    logic         out_vld8, f8;
`ifdef PRIMO_FACTOR_EN
    logic [W-1:0] factor;
    logic [7:0]   factor8;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic vld;
        logic f;
        int   factor;
    } exp_t;

    typedef struct {
        int   n;
        logic f;
        int   factor;
    } vec_t;

    exp_t sb[$];
    logic model_f;
    int   model_factor;

    always #5 clk = ~clk;

    primo_detector #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .in_vld (in_vld),
        .N      (n),
        .out_vld(out_vld),
        .F      (f)
`ifdef PRIMO_FACTOR_EN
        ,
        .FACTOR (factor)
`endif
    );

    primo_detector #(.W(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .in_vld (in_vld),
        .N      (n8),
        .out_vld(out_vld8),
        .F      (f8)
`ifdef PRIMO_FACTOR_EN
        ,
        .FACTOR (factor8)
`endif
    );

    // Plain trial division over every candidate divisor.
    function automatic logic ref_prime(int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d < v; d++) begin
            if (v % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int ref_factor(int v);
        if (v < 2) return 0;
        for (int d = 2; d < v; d++) begin
            if (v % d == 0) return d;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic drive(input logic r, input logic v, input int val, input int val8);
        exp_t e;
        rst    = r;
        in_vld = v;
        n      = W'(val);
        n8     = 8'(val8);
        if (r) begin
            model_f      = 1'b0;
            model_factor = 0;
            e.vld        = 1'b0;
        end else begin
            e.vld = v;
            if (v) begin
                model_f      = ref_prime(val);
                model_factor = ref_factor(val);
            end
        end
        e.f      = model_f;
        e.factor = model_factor;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("out_vld", 32'(out_vld), 32'(e.vld));
            chk("F", 32'(f), 32'(e.f));
`ifdef PRIMO_FACTOR_EN
            chk("FACTOR", 32'(factor), 32'(e.factor));
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t sweep[7];
        vec_t fvec[5];
        sweep = '{'{0, 1'b0, 0}, '{1, 1'b0, 0}, '{2, 1'b1, 0}, '{3, 1'b1, 0},
                  '{4, 1'b0, 2}, '{8, 1'b0, 2}, '{15, 1'b0, 3}};
        fvec  = '{'{15, 1'b0, 3}, '{9, 1'b0, 3}, '{8, 1'b0, 2}, '{7, 1'b1, 0}, '{1, 1'b0, 0}};
        model_f      = 1'b0;
        model_factor = 0;
        rst    = 1'b1;
        in_vld = 1'b1;
        n      = '0;
        n8     = '0;

        // Reset dominates a valid operand.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 3, 0);
            chk("reset_vld", 32'(out_vld), 32'd0);
            chk("reset_f", 32'(f), 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, sweep[i].n, 0);
            chk("sweep_f", 32'(f), 32'(sweep[i].f));
        end

        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, i, 0);
            chk("exh_vld", 32'(out_vld), 32'd1);
        end

        // F holds across idle cycles while out_vld drops.
        drive(1'b0, 1'b1, 13, 0);
        chk("hold_first_f", 32'(f), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4, 0);
            chk("hold_vld", 32'(out_vld), 32'd0);
            chk("hold_f", 32'(f), 32'd1);
        end

        // Reset mid-stream discards the pending operand.
        drive(1'b0, 1'b1, 11, 0);
        chk("mid_11_f", 32'(f), 32'd1);
        drive(1'b1, 1'b1, 12, 0);
        chk("mid_rst_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_f", 32'(f), 32'd0);

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, fvec[i].n, 0);
            chk("fvec_f", 32'(f), 32'(fvec[i].f));
`ifdef PRIMO_FACTOR_EN
            chk("fvec_factor", 32'(factor), 32'(fvec[i].factor));
`endif
        end

        drive(1'b0, 1'b1, 0, 251);
        chk("w8_251_vld", 32'(out_vld8), 32'd1);
        chk("w8_251_f", 32'(f8), 32'd1);
        chk("w8_251_ref", 32'(f8), 32'(ref_prime(251)));
        drive(1'b0, 1'b1, 0, 221);
        chk("w8_221_f", 32'(f8), 32'd0);
`ifdef PRIMO_FACTOR_EN
        chk("w8_221_factor", 32'(factor8), 32'd13);
`endif
        drive(1'b0, 1'b1, 0, 1);
        chk("w8_1_f", 32'(f8), 32'd0);
        drive(1'b0, 1'b1, 0, 2);
        chk("w8_2_f", 32'(f8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
